// File: rtl/veririsc_sequencer.sv
// veririsc_sequencer: eight-phase fetch/decode/execute sequencer for the VeriRISC CPU.
//
// Steps through INST_ADDR .. STORE once per instruction and decodes the current phase,
// opcode and accumulator-zero flag into the memory, IR, accumulator and PC strobes.
// inc_pc drives the program counter's enable and load_pc its load; the counter gives
// load priority, so a JMP that raises both in STORE lands on the target.
//
// Optional feature macro: VERIRISC_SEQ_HALT_STALL_EN
//   defined   : HLT parks the sequencer in OP_ADDR with halt held high until reset.
//   undefined : HLT gives a one-cycle halt pulse and sequencing carries on.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   opcode  in   [2:0] IR opcode (HLT SKZ ADD AND XOR LDA STO JMP = 0..7)
//   zero    in   accumulator-zero flag
//   phase   out  [2:0] current phase, for debug/trace
//   mem_rd  out  memory read strobe
//   load_ir out  instruction register load
//   halt    out  halt indication
//   inc_pc  out  program counter increment (counter enable)
//   load_ac out  accumulator load
//   load_pc out  program counter load (counter load)
//   mem_wr  out  memory write strobe
module veririsc_sequencer #(
  parameter int unsigned PHASES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic [2:0] phase,
  output logic       mem_rd,
  output logic       load_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       load_ac,
  output logic       load_pc,
  output logic       mem_wr
);

  if (PHASES != 8) begin : g_bad_phases
    $error("veririsc_sequencer: PHASES must be 8");
  end

  typedef enum logic [2:0] {
    StInstAddr  = 3'd0,
    StInstFetch = 3'd1,
    StInstLoad  = 3'd2,
    StIdle      = 3'd3,
    StOpAddr    = 3'd4,
    StOpFetch   = 3'd5,
    StAluOp     = 3'd6,
    StStore     = 3'd7
  } phase_e;

  localparam logic [2:0] OpHlt = 3'd0;
  localparam logic [2:0] OpSkz = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpAnd = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpLda = 3'd5;
  localparam logic [2:0] OpSto = 3'd6;
  localparam logic [2:0] OpJmp = 3'd7;

  phase_e phase_q, phase_d;
  logic   is_aluop;
  logic   is_hlt;

  assign is_aluop = (opcode == OpAdd) || (opcode == OpAnd) ||
                    (opcode == OpXor) || (opcode == OpLda);
  assign is_hlt   = (opcode == OpHlt);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= StInstAddr;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Next state: free-running 3-bit count, wrapping STORE -> INST_ADDR.
  always_comb begin
    phase_d = phase_e'(3'(phase_q + 3'd1));
`ifdef VERIRISC_SEQ_HALT_STALL_EN
    // Park on HLT; only reset gets us out.
    if ((phase_q == StOpAddr) && is_hlt) begin
      phase_d = phase_q;
    end
`endif
  end

  // Output decode.
  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    unique case (phase_q)
      StInstAddr: ;
      StInstFetch: begin
        mem_rd = 1'b1;
      end
      StInstLoad, StIdle: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      StOpAddr: begin
        halt = is_hlt;
`ifdef VERIRISC_SEQ_HALT_STALL_EN
        // A parked HLT must not keep advancing the PC.
        inc_pc = !is_hlt;
`else
        inc_pc = 1'b1;
`endif
      end
      StOpFetch: begin
        mem_rd = is_aluop;
      end
      StAluOp: begin
        mem_rd  = is_aluop;
        load_ac = is_aluop;
        inc_pc  = (opcode == OpSkz) && zero;
        load_pc = (opcode == OpJmp);
      end
      StStore: begin
        mem_rd  = is_aluop;
        load_ac = is_aluop;
        inc_pc  = (opcode == OpJmp);
        load_pc = (opcode == OpJmp);
        mem_wr  = (opcode == OpSto);
      end
      default: ;
    endcase
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_veririsc_sequencer.sv
// Directed bench for veririsc_sequencer, with a small program-counter model
// (load has priority over enable) to observe PC effects per instruction.
module tb_veririsc_sequencer;

  logic       clk;
  logic       reset;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;

  logic       pc_preset;
  logic [7:0] pc_data;
  logic [7:0] pc;

  int checks = 0;
  int errors = 0;

  veririsc_sequencer #(.PHASES(8)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .opcode  (opcode),
    .zero    (zero),
    .phase   (phase),
    .mem_rd  (mem_rd),
    .load_ir (load_ir),
    .halt    (halt),
    .inc_pc  (inc_pc),
    .load_ac (load_ac),
    .load_pc (load_pc),
    .mem_wr  (mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter: preset (bench only) > load > enable.
  always @(posedge clk) begin
    if (pc_preset)    pc <= 8'd5;
    else if (load_pc) pc <= pc_data;
    else if (inc_pc)  pc <= pc + 8'd1;
  end

  // {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}
  function automatic logic [6:0] strobes();
    return {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered at a negedge in phase 0; leaves at the negedge of the next phase 0.
  task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                           input logic [0:7][6:0] exp, input logic [7:0] pc_exp);
    opcode    = op;
    zero      = z;
    pc_preset = 1'b1;
    for (int p = 0; p < 8; p++) begin
      check_eq($sformatf("%s phase%0d", name, p), 32'(phase), 32'(p));
      check_eq($sformatf("%s strobes p%0d", name, p), 32'(strobes()), 32'(exp[p]));
      @(negedge clk);
      pc_preset = 1'b0;
    end
    check_eq({name, " pc"}, 32'(pc), 32'(pc_exp));
  endtask

  initial begin
    reset     = 1'b0;
    opcode    = 3'd2;
    zero      = 1'b0;
    pc_preset = 1'b0;
    pc_data   = 8'h1A;

    repeat (3) begin
      @(negedge clk);
      check_eq("reset phase", 32'(phase), 32'd0);
      check_eq("reset strobes", 32'(strobes()), 32'd0);
    end

    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check_eq($sformatf("release step%0d", i), 32'(phase), 32'(i % 8));
    end

    //                      p0        p1        p2        p3        p4        p5        p6        p7
    run_instr("ADD", 3'd2, 1'b0, {7'h00, 7'h40, 7'h60, 7'h60, 7'h08, 7'h40, 7'h44, 7'h44}, 8'd6);
    run_instr("SKZ1", 3'd1, 1'b1, {7'h00, 7'h40, 7'h60, 7'h60, 7'h08, 7'h00, 7'h08, 7'h00}, 8'd7);
    run_instr("SKZ0", 3'd1, 1'b0, {7'h00, 7'h40, 7'h60, 7'h60, 7'h08, 7'h00, 7'h00, 7'h00}, 8'd6);
    run_instr("JMP", 3'd7, 1'b0, {7'h00, 7'h40, 7'h60, 7'h60, 7'h08, 7'h00, 7'h02, 7'h0A}, 8'h1A);
    run_instr("STO", 3'd6, 1'b0, {7'h00, 7'h40, 7'h60, 7'h60, 7'h08, 7'h00, 7'h00, 7'h01}, 8'd6);

`ifdef VERIRISC_SEQ_HALT_STALL_EN
    opcode = 3'd0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("stall phase%0d", i), 32'(phase), 32'd4);
      check_eq($sformatf("stall strobes%0d", i), 32'(strobes()), 32'h10);
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    check_eq("stall reset phase", 32'(phase), 32'd0);
    check_eq("stall reset halt", 32'(halt), 32'd0);
`else
    run_instr("HLT", 3'd0, 1'b0, {7'h00, 7'h40, 7'h60, 7'h60, 7'h18, 7'h00, 7'h00, 7'h00}, 8'd6);
    // Abort an ADD in OP_FETCH with an asynchronous reset.
    opcode = 3'd2;
    repeat (5) @(negedge clk);
    check_eq("abort pre phase", 32'(phase), 32'd5);
    check_eq("abort pre mem_rd", 32'(mem_rd), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("abort phase", 32'(phase), 32'd0);
    check_eq("abort strobes", 32'(strobes()), 32'd0);
`endif

    @(posedge clk);
    #1;
    check_eq("held reset phase", 32'(phase), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("re-release phase", 32'(phase), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
